// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg: shared types and counter widths for data_mem_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int MAX_STARVE_LIMIT = 15;
  localparam int MAX_BURST_LIMIT  = 16;
  localparam int STARVE_W         = $clog2(MAX_STARVE_LIMIT + 1);
  localparam int BEAT_W           = $clog2(MAX_BURST_LIMIT + 1);

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter: up-counter saturating at MAX; clr with inc restarts at 1. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter: CPU/DMA arbiter for the single-port data memory with
// starvation bound and locked DMA bursts. Optional ARB_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_lock,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           stat_cpu_stalls,
  output logic [31:0]           stat_dma_beats
);

  arb_state_t            state_q;
  arb_state_t            state_d;
  owner_t                owner;
  logic                  burst_exit;
  logic                  cpu_pref_q;
  logic                  cpu_gnt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  dma_rvalid_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  // DMA is never granted while reset is held, so a reset mid-burst drops ownership at once.
  always_comb begin
    owner      = OWN_NONE;
    state_d    = state_q;
    burst_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_req && reset &&
            (!cpu_req || ((starve_cnt == STARVE_W'(MAX_STARVE)) && !cpu_pref_q))) begin
          owner = OWN_DMA;
        end else if (cpu_req) begin
          owner = OWN_CPU;
        end
        if ((owner == OWN_DMA) && dma_lock) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (dma_req && reset) begin
          owner = OWN_DMA;
        end
        if ((owner != OWN_DMA) || !dma_lock ||
            ((beat_cnt + 1'b1) == BEAT_W'(MAX_BURST))) begin
          burst_exit = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_gnt   = (owner == OWN_CPU);
  assign dma_gnt   = (owner == OWN_DMA);
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;

  assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
  assign mem_re    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
  assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cpu_pref_q   <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cpu_pref_q   <= burst_exit;
      dma_rvalid_q <= dma_gnt & ~dma_we;
      if (dma_gnt && !dma_we) begin
        dma_rdata_q <= mem_rdata;
      end
    end
  end

  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

  sat_counter #(
    .W   (STARVE_W),
    .MAX (STARVE_W'(MAX_STARVE))
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_req & ~dma_gnt),
    .clr   (dma_gnt),
    .cnt   (starve_cnt)
  );

  // Entering a burst restarts the beat count at 1 (clr and inc together).
  sat_counter #(
    .W   (BEAT_W),
    .MAX (BEAT_W'(MAX_BURST))
  ) u_beat (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_gnt && (state_d == BURST)),
    .clr   ((state_d == IDLE) || (state_q == IDLE)),
    .cnt   (beat_cnt)
  );

`ifdef ARB_STATS_EN
  sat_counter #(
    .W   (32),
    .MAX (32'hFFFF_FFFF)
  ) u_stat_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_stall),
    .clr   (1'b0),
    .cnt   (stat_cpu_stalls)
  );

  sat_counter #(
    .W   (32),
    .MAX (32'hFFFF_FFFF)
  ) u_stat_beats (
    .clk   (clk),
    .reset (reset),
    .inc   (dma_gnt),
    .clr   (1'b0),
    .cnt   (stat_dma_beats)
  );
`else
  assign stat_cpu_stalls = '0;
  assign stat_dma_beats  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
`ifdef ARB_STATS_EN
  localparam logic [31:0] EXP_STAT = 32'd8;
`else
  localparam logic [31:0] EXP_STAT = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_lock, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [31:0]   stat_cpu_stalls, stat_dma_beats;

  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] sb_q [$];
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  data_mem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_stall       (cpu_stall),
    .dma_req         (dma_req),
    .dma_lock        (dma_lock),
    .dma_we          (dma_we),
    .dma_addr        (dma_addr),
    .dma_wdata       (dma_wdata),
    .dma_gnt         (dma_gnt),
    .dma_rvalid      (dma_rvalid),
    .dma_rdata       (dma_rdata),
    .mem_we          (mem_we),
    .mem_re          (mem_re),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .stat_cpu_stalls (stat_cpu_stalls),
    .stat_dma_beats  (stat_dma_beats)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [DW-1:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, dma_rdata);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, dma_rdata, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_set(input logic req, input logic lock, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = req; dma_lock = lock; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    int waits;
    reset = 1'b0;
    cpu_set(0, 0, '0, '0);
    dma_set(0, 0, 0, '0, '0);
    tick();
    tick();
    chk("rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_rdata", dma_rdata, 32'd0);
    chk("rst_stat_stall", stat_cpu_stalls, 32'd0);
    chk("rst_stat_beats", stat_dma_beats, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    reset = 1'b1;
    tick();

    // CPU write then read-back, DMA idle
    cpu_set(1, 1, 10'd5, 32'hA5A5_0001);
    #1;
    chk("t1_mem_we", 32'(mem_we), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd5);
    chk("t1_mem_wdata", mem_wdata, 32'hA5A5_0001);
    chk("t1_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_set(1, 0, 10'd5, '0);
    #1;
    chk("t1_rdata", cpu_rdata, 32'hA5A5_0001);
    chk("t1_mem_re", 32'(mem_re), 32'd1);
    chk("t1_rd_we", 32'(mem_we), 32'd0);
    tick();
    cpu_set(1, 1, 10'd9, 32'h0000_CAFE);
    tick();

    // Contention: CPU for MAX_STARVE cycles, then DMA read
    cpu_set(1, 0, 10'd5, '0);
    dma_set(1, 0, 0, 10'd9, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_cpu_win%0d_gnt", i), 32'(dma_gnt), 32'd0);
      chk($sformatf("t2_cpu_win%0d_stall", i), 32'(cpu_stall), 32'd0);
      tick();
    end
    #1;
    chk("t2_dma_gnt", 32'(dma_gnt), 32'd1);
    chk("t2_stall", 32'(cpu_stall), 32'd1);
    chk("t2_mem_addr", 32'(mem_addr), 32'd9);
    if (dma_gnt) sb_q.push_back(32'h0000_CAFE);
    tick();
    dma_set(0, 0, 0, '0, '0);
    #1;
    chk("t2_rvalid", 32'(dma_rvalid), 32'd1);
    sb_pop("t2_rdata");
    chk("t2_starve", 32'(dut.starve_cnt), 32'd0);
    chk("t2_cpu_back", 32'(cpu_stall), 32'd0);
    tick();
    chk("t2_rvalid_drop", 32'(dma_rvalid), 32'd0);

    // Locked burst against a continuously requesting CPU
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cpu_set(1, 0, 10'd5, '0);
    dma_set(1, 1, 1, 10'd100, 32'hD000_0000);
    waits = 0;
    #1;
    while (!dma_gnt && waits < 10) begin
      tick();
      #1;
      waits++;
    end
    chk("t3_wait", 32'(waits), 32'd4);
    for (int i = 0; i < 8; i++) begin
      dma_addr  = AW'(100 + i);
      dma_wdata = 32'hD000_0000 + 32'(i);
      #1;
      chk($sformatf("t3_beat%0d_gnt", i), 32'(dma_gnt), 32'd1);
      chk($sformatf("t3_beat%0d_stall", i), 32'(cpu_stall), 32'd1);
      chk($sformatf("t3_beat%0d_addr", i), 32'(mem_addr), 32'(100 + i));
      tick();
    end
    dma_addr  = 10'd108;
    dma_wdata = 32'hD000_0008;
    #1;
    chk("t3_after_gnt", 32'(dma_gnt), 32'd0);
    chk("t3_after_stall", 32'(cpu_stall), 32'd0);
    chk("t3_stat_beats", stat_dma_beats, EXP_STAT);
    chk("t3_stat_stalls", stat_cpu_stalls, EXP_STAT);
    cpu_set(0, 0, '0, '0);
    dma_set(0, 0, 0, '0, '0);
    tick();

    // Lock dropped on beat 3
    dma_set(1, 1, 1, 10'd200, 32'hE000_0000);
    #1;
    chk("t4_b1_gnt", 32'(dma_gnt), 32'd1);
    tick();
    cpu_set(1, 0, 10'd5, '0);
    dma_set(1, 1, 1, 10'd201, 32'hE000_0001);
    #1;
    chk("t4_b2_gnt", 32'(dma_gnt), 32'd1);
    chk("t4_b2_stall", 32'(cpu_stall), 32'd1);
    tick();
    dma_set(1, 0, 1, 10'd202, 32'hE000_0002);
    #1;
    chk("t4_b3_gnt", 32'(dma_gnt), 32'd1);
    tick();
    dma_set(1, 0, 1, 10'd203, 32'hE000_0003);
    #1;
    chk("t4_next_gnt", 32'(dma_gnt), 32'd0);
    chk("t4_next_stall", 32'(cpu_stall), 32'd0);
    dma_set(0, 0, 0, '0, '0);
    cpu_set(1, 0, 10'd107, '0);
    tick();
    chk("t4_burst_mem", cpu_rdata, 32'hD000_0007);
    cpu_set(0, 0, '0, '0);
    dma_set(1, 0, 0, 10'd202, '0);
    #1;
    chk("t4_rd_gnt", 32'(dma_gnt), 32'd1);
    if (dma_gnt) sb_q.push_back(32'hE000_0002);
    tick();
    dma_set(0, 0, 0, '0, '0);
    #1;
    chk("t4_rvalid", 32'(dma_rvalid), 32'd1);
    sb_pop("t4_rdata");
    tick();

    // Reset asserted on beat 2 of a burst
    dma_set(1, 1, 0, 10'd5, '0);
    #1;
    chk("t5_b1_gnt", 32'(dma_gnt), 32'd1);
    if (dma_gnt) sb_q.push_back(32'hA5A5_0001);
    tick();
    cpu_set(1, 0, 10'd5, '0);
    dma_set(1, 1, 1, 10'd301, 32'hBAD0_0001);
    #1;
    chk("t5_b2_gnt", 32'(dma_gnt), 32'd1);
    chk("t5_b2_mem_we", 32'(mem_we), 32'd1);
    chk("t5_b2_rvalid", 32'(dma_rvalid), 32'd1);
    sb_pop("t5_b1_rdata");
    reset = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(dma_gnt), 32'd0);
    chk("t5_rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("t5_rst_mem_we", 32'(mem_we), 32'd0);
    chk("t5_rst_rdata", dma_rdata, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("t5_post_gnt", 32'(dma_gnt), 32'd0);
    chk("t5_post_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_set(0, 0, '0, '0);
    dma_set(0, 0, 0, '0, '0);
    tick();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
